// File: rtl/moore_seq_detect.sv
// moore_seq_detect: parametrised Moore serial sequence detector.
// Recognises a LEN-bit PATTERN (PATTERN[LEN-1] arrives first) on a
// single-bit stream. Detection can overlap or not; the mode is chosen at run time.
// The next-state tables come from the KMP failure function, which the
// design computes from PATTERN at elaboration time.
// Optional feature: define MOORE_SEQ_CNT_EN to build the saturating
// match counter. Without it, match_count is tied to 0.
//
// Handshake: a bit on 'in' is consumed on a rising edge only while
// in_valid is high. There is no ready and no back-pressure. While in_valid
// is low, the state and 'out' hold.
// state_dbg exposes the FSM state (S0..S<LEN>) for checkers.
module moore_seq_detect #(
  parameter int             LEN     = 5,
  parameter logic [LEN-1:0] PATTERN = 5'b11011,
  parameter int             CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       overlap,
  output logic                       out,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(LEN+1)-1:0]   state_dbg
);

  localparam int SW = $clog2(LEN+1);
  localparam int NS = 2**SW;

  // Refuse to elaborate with an unsupported pattern length
  if (LEN < 2 || LEN > 16) begin : g_len_check
    $error("moore_seq_detect: LEN must be in 2..16");
  end

  // Pattern bit in arrival order: index 0 is the first bit received
  function automatic logic pat_bit(input int i);
    logic [LEN-1:0] sh;
    sh = PATTERN >> (LEN - 1 - i);
    return sh[0];
  endfunction

  // Longest suffix of (prefix_k . b) that is also a pattern prefix
  function automatic int kmp_next(input int k, input logic b);
    int   res;
    int   idx;
    logic ok;
    logic sbit;
    res = 0;
    for (int j = 1; j <= LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < LEN; m++) begin
          if (m < j) begin
            idx  = k + 1 - j + m;
            sbit = (idx == k) ? b : pat_bit(idx);
            if (sbit != pat_bit(m)) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Longest proper border of the whole pattern: the resume point after an overlapping match
  function automatic int border_len();
    int   res;
    logic ok;
    res = 0;
    for (int j = 1; j < LEN; j++) begin
      ok = 1'b1;
      for (int m = 0; m < LEN; m++) begin
        if (m < j) begin
          if (pat_bit(LEN - j + m) != pat_bit(m)) ok = 1'b0;
        end
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  localparam logic [SW-1:0] S_MATCH  = SW'(LEN);
  localparam logic [SW-1:0] S_BORDER = SW'(border_len());

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;
  logic [SW-1:0] base_state;
  logic [SW-1:0] tbl0 [NS];
  logic [SW-1:0] tbl1 [NS];

  // Constant transition tables indexed by state. Unreachable codes fall back to S0.
  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < LEN) begin : g_live
      localparam int N0 = kmp_next(k, 1'b0);
      localparam int N1 = kmp_next(k, 1'b1);
      assign tbl0[k] = SW'(N0);
      assign tbl1[k] = SW'(N1);
    end else begin : g_dead
      assign tbl0[k] = '0;
      assign tbl1[k] = '0;
    end
  end

  // State register: synchronous reset wins over in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
    end else if (in_valid) begin
      state <= next_state;
    end
  end

  // Next state: leave MATCH through the border (overlap) or S0, then apply the bit
  always_comb begin
    base_state = state;
    if (state == S_MATCH) begin
      base_state = overlap ? S_BORDER : '0;
    end
    next_state = in ? tbl1[base_state] : tbl0[base_state];
  end

  // Moore outputs: functions of state only
  always_comb begin
    out       = (state == S_MATCH);
    state_dbg = state;
  end

`ifdef MOORE_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Count every consumed bit that lands in MATCH, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_valid && (next_state == S_MATCH) && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_count = cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detect.sv
// Testbench for moore_seq_detect: directed vectors with hand-computed
// expected values, using three instances (default 11011, 4-bit 1111, 2-bit counter).
module tb_moore_seq_detect;

`ifdef MOORE_SEQ_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;

  logic       out_a;
  logic [7:0] cnt_a;
  logic [2:0] st_a;
  logic       out_b;
  logic [7:0] cnt_b;
  logic [2:0] st_b;
  logic       out_c;
  logic [1:0] cnt_c;
  logic [2:0] st_c;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  moore_seq_detect u_dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .out(out_a), .match_count(cnt_a), .state_dbg(st_a)
  );

  moore_seq_detect #(.LEN(4), .PATTERN(4'b1111)) u_p4 (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .out(out_b), .match_count(cnt_b), .state_dbg(st_b)
  );

  moore_seq_detect #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .overlap(overlap),
    .out(out_c), .match_count(cnt_c), .state_dbg(st_c)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic b);
    in = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  // Feed n bits (MSB first) into all instances and score out_a against exp_out
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input logic [15:0] exp_out, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back({31'd0, exp_out[i]});
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      check($sformatf("%s_out[%0d]", tag, n - i), {31'd0, out_a}, exp_q.pop_front());
    end
  endtask

  initial begin
    // reset state
    overlap = 1'b1;
    apply_reset();
    check("rst_out", {31'd0, out_a}, 32'd0);
    check("rst_state", {29'd0, st_a}, 32'd0);
    check("rst_cnt", {24'd0, cnt_a}, 32'd0);

    // overlapping: matches after bits 5, 8, 12
    run_stream("ovl", 16'b110110111011, 16'b000010010001, 12);
    check("ovl_cnt", {24'd0, cnt_a}, CNT_ON ? 32'd3 : 32'd0);

    // non-overlapping: matches after bits 5 and 12 only
    overlap = 1'b0;
    apply_reset();
    run_stream("nov", 16'b110110111011, 16'b000010000001, 12);
    check("nov_cnt", {24'd0, cnt_a}, CNT_ON ? 32'd2 : 32'd0);

    // in_valid gap of 3 cycles between bits 3 and 4
    overlap = 1'b1;
    apply_reset();
    run_stream("gap_pre", 16'b110, 16'b000, 3);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check($sformatf("gap_out[%0d]", i), {31'd0, out_a}, 32'd0);
      check($sformatf("gap_state[%0d]", i), {29'd0, st_a}, 32'd3);
    end
    run_stream("gap_post", 16'b11, 16'b01, 2);
    check("gap_cnt", {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);
    // held MATCH: out stays high, no re-count
    for (int i = 0; i < 2; i++) begin
      idle_cycle();
      check($sformatf("hold_out[%0d]", i), {31'd0, out_a}, 32'd1);
      check($sformatf("hold_cnt[%0d]", i), {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);
    end
    // leave MATCH through the border: S2 + 0 -> S3
    send(1'b0);
    check("exit_state", {29'd0, st_a}, 32'd3);
    check("exit_out", {31'd0, out_a}, 32'd0);

    // reset mid-stream discards the partial match
    apply_reset();
    run_stream("rm_pre", 16'b1101, 16'b0000, 4);
    apply_reset();
    check("rm_state", {29'd0, st_a}, 32'd0);
    check("rm_out", {31'd0, out_a}, 32'd0);
    run_stream("rm_one", 16'b1, 16'b0, 1);
    check("rm_one_state", {29'd0, st_a}, 32'd1);
    run_stream("rm_post", 16'b11011, 16'b00001, 5);
    check("rm_cnt", {24'd0, cnt_a}, CNT_ON ? 32'd1 : 32'd0);

    // overlap is only sampled when leaving MATCH
    apply_reset();
    overlap = 1'b0; send(1'b1);
    overlap = 1'b1; send(1'b1);
    overlap = 1'b0; send(1'b0);
    send(1'b1);
    check("mode_mid_state", {29'd0, st_a}, 32'd4);
    overlap = 1'b1; send(1'b1);
    check("mode_match", {31'd0, out_a}, 32'd1);
    send(1'b0);
    check("mode_ovl_exit", {29'd0, st_a}, 32'd3);
    send(1'b1);
    send(1'b1);
    check("mode_match2", {31'd0, out_a}, 32'd1);
    overlap = 1'b0; send(1'b1);
    check("mode_nov_exit", {29'd0, st_a}, 32'd1);

    // LEN=4, 1111 overlapping: MATCH -> MATCH on every further 1
    overlap = 1'b1;
    apply_reset();
    for (int i = 1; i <= 7; i++) begin
      send(1'b1);
      check($sformatf("p4_out[%0d]", i), {31'd0, out_b}, (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("p4_state[%0d]", i), {29'd0, st_b}, (i >= 4) ? 32'd4 : 32'(i));
    end
    check("p4_cnt", {24'd0, cnt_b}, CNT_ON ? 32'd4 : 32'd0);

    // CNT_W=2 saturation: five matches stop the count at 3
    overlap = 1'b0;
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      send(1'b1); send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      check($sformatf("sat_out[%0d]", r), {31'd0, out_c}, 32'd1);
      check($sformatf("sat_cnt[%0d]", r), {30'd0, cnt_c},
            CNT_ON ? ((r >= 2) ? 32'd3 : 32'(r + 1)) : 32'd0);
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
